// File: rtl/game_flow_ctrl.sv
// Sudoku game-flow controller: IDLE/GAMING/PAUSED/WON/LOST sequencing,
// difficulty-level selection and an elapsed-time counter for display.
module game_flow_ctrl #(
    parameter int TICK_DIV   = 100000000,
    parameter int TIME_W     = 10,
    parameter int TIME_LIMIT = 0,
    parameter int NUM_LEVELS = 4,
    parameter int LEVEL_W    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               btn_c,
    input  logic               btn_u,
    input  logic               btn_d,
    input  logic               quit,
    input  logic               win_tag,
    output logic [2:0]         glob_state,
    output logic               init_tag,
    output logic               sig_newgame,
    output logic [LEVEL_W-1:0] level,
    output logic [TIME_W-1:0]  elapsed,
    output logic               timeout_tag
);

    localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [LEVEL_W-1:0] LVL_MAX = LEVEL_W'(NUM_LEVELS - 1);
    localparam logic [TIME_W-1:0] T_LIM = TIME_W'(TIME_LIMIT);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GAMING = 3'd1,
        S_PAUSED = 3'd2,
        S_WON    = 3'd3,
        S_LOST   = 3'd4
    } state_t;

    state_t state_q;
    state_t state_d;

    logic               btn_c_q;
    logic               btn_u_q;
    logic               btn_d_q;
    logic               newgame_q;
    logic [LEVEL_W-1:0] level_q;
    logic [TIME_W-1:0]  elapsed_q;
    logic [PRE_W-1:0]   pre_q;

    logic press_c;
    logic press_u;
    logic press_d;
    logic time_up;
    logic new_game;

    assign press_c  = btn_c & ~btn_c_q;
    assign press_u  = btn_u & ~btn_u_q;
    assign press_d  = btn_d & ~btn_d_q;
    assign time_up  = (TIME_LIMIT != 0) && (elapsed_q == T_LIM);
    assign new_game = (state_q == S_IDLE) && (state_d == S_GAMING);

    // quit beats everything, then win, then timeout, then pause
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (press_c) state_d = S_GAMING;
            end
            S_GAMING: begin
                if (quit)         state_d = S_IDLE;
                else if (win_tag) state_d = S_WON;
                else if (time_up) state_d = S_LOST;
                else if (press_c) state_d = S_PAUSED;
            end
            S_PAUSED: begin
                if (quit)         state_d = S_IDLE;
                else if (press_c) state_d = S_GAMING;
            end
            S_WON, S_LOST: begin
                if (press_c || quit) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // edge-detect registers reset high so a held button is not a press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            btn_c_q   <= 1'b1;
            btn_u_q   <= 1'b1;
            btn_d_q   <= 1'b1;
            newgame_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            btn_c_q   <= btn_c;
            btn_u_q   <= btn_u;
            btn_d_q   <= btn_d;
            newgame_q <= new_game;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= '0;
        end else if (state_q == S_IDLE) begin
            if (press_u && !press_d && level_q != LVL_MAX)
                level_q <= level_q + 1'b1;
            else if (press_d && !press_u && level_q != '0)
                level_q <= level_q - 1'b1;
        end
    end

    // prescaler only advances in GAMING, so paused time is not counted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q     <= '0;
            elapsed_q <= '0;
        end else if (new_game) begin
            pre_q     <= '0;
            elapsed_q <= '0;
        end else if (state_q == S_GAMING) begin
            if (pre_q == PRE_LAST) begin
                pre_q <= '0;
                if (elapsed_q != '1)
                    elapsed_q <= elapsed_q + 1'b1;
            end else begin
                pre_q <= pre_q + 1'b1;
            end
        end
    end

    assign glob_state  = state_q;
    assign init_tag    = (state_q == S_GAMING);
    assign timeout_tag = (state_q == S_LOST);
    assign sig_newgame = newgame_q;
    assign level       = level_q;
    assign elapsed     = elapsed_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: directed scenarios plus random stimulus,
// all checked against a cycle-count based reference model.
module tb_game_flow_ctrl;

    localparam int TD = 4;
    localparam int TW = 4;
    localparam int TL = 3;
    localparam int NL = 3;
    localparam int LW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          btn_c = 1'b0;
    logic          btn_u = 1'b0;
    logic          btn_d = 1'b0;
    logic          quit = 1'b0;
    logic          win_tag = 1'b0;
    logic [2:0]    glob_state;
    logic          init_tag;
    logic          sig_newgame;
    logic [LW-1:0] level;
    logic [TW-1:0] elapsed;
    logic          timeout_tag;

    int n_chk = 0;
    int n_fail = 0;

    int m_st;
    int m_lvl;
    int m_gcnt;
    bit m_ng;
    bit pc;
    bit pu;
    bit pd;

    game_flow_ctrl #(
        .TICK_DIV  (TD),
        .TIME_W    (TW),
        .TIME_LIMIT(TL),
        .NUM_LEVELS(NL),
        .LEVEL_W   (LW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_c      (btn_c),
        .btn_u      (btn_u),
        .btn_d      (btn_d),
        .quit       (quit),
        .win_tag    (win_tag),
        .glob_state (glob_state),
        .init_tag   (init_tag),
        .sig_newgame(sig_newgame),
        .level      (level),
        .elapsed    (elapsed),
        .timeout_tag(timeout_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    // elapsed is just the GAMING cycle count divided down, saturated
    function automatic int m_el();
        int e;
        e = m_gcnt / TD;
        if (e > (1 << TW) - 1) e = (1 << TW) - 1;
        return e;
    endfunction

    task automatic model_reset();
        m_st = 0;
        m_lvl = 0;
        m_gcnt = 0;
        m_ng = 0;
        pc = 1;
        pu = 1;
        pd = 1;
    endtask

    task automatic model_step();
        bit c;
        bit u;
        bit d;
        int nx;
        c = btn_c && !pc;
        u = btn_u && !pu;
        d = btn_d && !pd;
        nx = m_st;
        case (m_st)
            0: if (c) nx = 1;
            1: begin
                if (quit) nx = 0;
                else if (win_tag) nx = 3;
                else if (TL != 0 && m_el() == TL) nx = 4;
                else if (c) nx = 2;
            end
            2: begin
                if (quit) nx = 0;
                else if (c) nx = 1;
            end
            default: if (c || quit) nx = 0;
        endcase
        if (m_st == 0) begin
            if (u && !d && m_lvl < NL - 1) m_lvl++;
            if (d && !u && m_lvl > 0) m_lvl--;
        end
        if (m_st == 1) m_gcnt++;
        m_ng = (m_st == 0 && nx == 1);
        if (m_ng) m_gcnt = 0;
        m_st = nx;
        pc = btn_c;
        pu = btn_u;
        pd = btn_d;
    endtask

    task automatic check_all();
        chk("state", 32'(glob_state), 32'(m_st));
        chk("init_tag", 32'(init_tag), 32'(m_st == 1));
        chk("timeout_tag", 32'(timeout_tag), 32'(m_st == 4));
        chk("sig_newgame", 32'(sig_newgame), 32'(m_ng));
        chk("level", 32'(level), 32'(m_lvl));
        chk("elapsed", 32'(elapsed), 32'(m_el()));
    endtask

    task automatic step(input bit c, input bit u, input bit d,
                        input bit q, input bit w);
        btn_c = c;
        btn_u = u;
        btn_d = d;
        quit = q;
        win_tag = w;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    // reset asserted between edges; outputs must clear before next edge
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_state", 32'(glob_state), 0);
        chk("rst_init", 32'(init_tag), 0);
        chk("rst_newgame", 32'(sig_newgame), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_elapsed", 32'(elapsed), 0);
        chk("rst_timeout", 32'(timeout_tag), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int lv_exp[5];
        lv_exp = '{1, 2, 2, 2, 2};
        btn_c = 1'b1;
        @(negedge clk);
        do_reset();

        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
        chk("held_c_idle", 32'(glob_state), 0);

        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 0, 0);
            chk("lvl_up", 32'(level), 32'(lv_exp[i]));
            step(0, 0, 0, 0, 0);
        end
        step(0, 0, 1, 0, 0);
        chk("lvl_dn", 32'(level), 1);
        step(0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        chk("lvl_both", 32'(level), 1);

        step(1, 0, 0, 0, 0);
        chk("ng_state", 32'(glob_state), 1);
        chk("ng_pulse", 32'(sig_newgame), 1);
        chk("ng_elapsed", 32'(elapsed), 0);
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0);
        chk("held_c_gaming", 32'(glob_state), 1);
        step(0, 0, 0, 1, 0);
        chk("quit_idle", 32'(glob_state), 0);

        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        idle_steps(4);
        step(1, 0, 0, 0, 0);
        chk("pause_state", 32'(glob_state), 2);
        chk("pause_el", 32'(elapsed), 1);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, i[2]);
        chk("pause_hold", 32'(elapsed), 1);
        chk("win_paused", 32'(glob_state), 2);
        step(1, 0, 0, 0, 0);
        chk("resume_state", 32'(glob_state), 1);
        chk("resume_ng", 32'(sig_newgame), 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("resume_el", 32'(elapsed), 2);
        step(1, 0, 0, 0, 0);
        chk("pause2_el", 32'(elapsed), 2);
        do_reset();
        chk("reset_level", 32'(level), 0);

        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        idle_steps(11);
        chk("to_el", 32'(elapsed), 3);
        chk("to_state_pre", 32'(glob_state), 1);
        step(0, 0, 0, 0, 0);
        chk("to_state", 32'(glob_state), 4);
        chk("to_tag", 32'(timeout_tag), 1);
        chk("to_el_hold", 32'(elapsed), 3);
        idle_steps(3);
        step(1, 0, 0, 0, 0);
        chk("lost_idle", 32'(glob_state), 0);

        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        idle_steps(11);
        step(0, 0, 0, 0, 1);
        chk("win_vs_to", 32'(glob_state), 3);
        step(0, 0, 0, 1, 0);
        chk("won_quit", 32'(glob_state), 0);

        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1);
        chk("quit_vs_win", 32'(glob_state), 0);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 2) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 39) == 0,
                 $urandom_range(0, 24) == 0);
            if ($urandom_range(0, 499) == 0) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
